// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: receiver state encoding,
// frame geometry, parameter defaults and the odd-parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DPS   = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    localparam int FRAME_BITS      = 11;
    localparam int DATA_BITS       = 8;
    localparam int FILTER_LEN_DEF  = 8;
    localparam int FIFO_AW_DEF     = 2;
    localparam int TIMEOUT_CYC_DEF = 20000;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// Synchronous first-word-fall-through FIFO, 8 bits wide, 2**FIFO_AW deep.
// The head entry is presented on rd_data straight from storage; a pop
// advances the read pointer on the next clock edge.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   wr_en    in   push wr_data (accepted when not full, or when popping)
//   wr_data  in   byte to push
//   rd_en    in   pop head entry (ignored when empty)
//   rd_data  out  head entry
//   empty    out  no entries held
//   full     out  all entries held
//   count    out  number of entries held
// ---------------------------------------------------------------------------
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     count
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q;
    logic [FIFO_AW-1:0]   rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic                 do_pop;
    logic                 do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push
    // when it is being read.
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_buf.sv
// ---------------------------------------------------------------------------
// ps2_rx_buf
// PS/2 device-to-host receiver: ps2c glitch filter, 11-bit frame capture,
// start/stop/parity validation, inter-edge timeout and a receive FIFO with
// first-word-fall-through read side.
//
// Build option: define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd
// parity (parity_err_tick). Without it the parity bit is ignored and
// parity_err_tick stays 0.
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous, active-high
//   ps2d             in   PS/2 data (synchronised)
//   ps2c             in   PS/2 clock (synchronised)
//   rx_en            in   permits a new frame to start
//   rd_en            in   pop FIFO head (ignored when empty)
//   dout             out  FIFO head byte, valid when !empty
//   empty            out  FIFO empty
//   full             out  FIFO full
//   count            out  FIFO entries held
//   rx_done_tick     out  valid frame written to FIFO
//   frame_err_tick   out  bad start/stop bit, or inter-edge timeout
//   parity_err_tick  out  parity mismatch
//   overflow_tick    out  valid frame dropped because FIFO full
//
// Receiver states
//   state     | meaning
//   ST_IDLE   | waiting for a start-bit falling edge while rx_en is high
//   ST_DPS    | collecting data, parity and stop bits; timeout running
//   ST_CHECK  | one cycle: validate frame, write FIFO or raise error tick
// ---------------------------------------------------------------------------
module ps2_rx_buf
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int FIFO_AW     = FIFO_AW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2d,
    input  logic                 ps2c,
    input  logic                 rx_en,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full,
    output logic [FIFO_AW:0]     count,
    output logic                 rx_done_tick,
    output logic                 frame_err_tick,
    output logic                 parity_err_tick,
    output logic                 overflow_tick
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    // ---------------- ps2c glitch filter ----------------
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic [FILTER_LEN-1:0] filt_sr_d;
    logic                  filt_q;
    logic                  filt_d;
    logic                  fall_edge;

    assign filt_sr_d = {ps2c, filt_sr_q[FILTER_LEN-1:1]};

    // Level only changes once the whole window agrees; mixed windows hold.
    always_comb begin
        filt_d = filt_q;
        if (&filt_sr_d) begin
            filt_d = 1'b1;
        end else if (~|filt_sr_d) begin
            filt_d = 1'b0;
        end
    end

    // Edge is flagged in the cycle the filter resolves low, so ps2d is
    // sampled while the filtered clock is still nominally falling.
    assign fall_edge = filt_q & ~filt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_sr_q <= '0;
            filt_q    <= 1'b0;
        end else begin
            filt_sr_q <= filt_sr_d;
            filt_q    <= filt_d;
        end
    end

    // ---------------- frame receiver ----------------
    rx_state_e             state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [3:0]            n_q;
    logic [TMO_W-1:0]      tmo_q;

    logic                  tmo_expire;
    logic                  in_check;
    logic                  frame_bad;
    logic                  parity_bad;
    logic                  accept;
    logic                  fifo_wr;

    // Expires in the TIMEOUT_CYC-th consecutive edge-free cycle after the
    // last edge of a frame.
    assign tmo_expire = (state_q == ST_DPS) & ~fall_edge &
                        (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            n_q     <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_edge && rx_en) begin
                        frame_q <= {ps2d, frame_q[FRAME_BITS-1:1]};
                        n_q     <= 4'd9;
                        tmo_q   <= '0;
                        state_q <= ST_DPS;
                    end
                end
                ST_DPS: begin
                    if (fall_edge) begin
                        frame_q <= {ps2d, frame_q[FRAME_BITS-1:1]};
                        tmo_q   <= '0;
                        if (n_q == 4'd0) begin
                            state_q <= ST_CHECK;
                        end else begin
                            n_q <= n_q - 1'b1;
                        end
                    end else if (tmo_expire) begin
                        tmo_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Frame layout after capture: [0] start, [8:1] data, [9] parity, [10] stop.
    assign in_check  = (state_q == ST_CHECK);
    assign frame_bad = frame_q[0] | ~frame_q[FRAME_BITS-1];

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_bad = ~odd_parity_ok(frame_q[8:1], frame_q[9]);
`else
    logic unused_parity_bit;
    assign unused_parity_bit = frame_q[9];
    assign parity_bad        = 1'b0;
`endif

    // Error ticks take priority; overflow and done are mutually exclusive.
    assign accept          = in_check & ~frame_bad & ~parity_bad;
    assign fifo_wr         = accept & (~full | rd_en);
    assign rx_done_tick    = fifo_wr;
    assign overflow_tick   = accept & full & ~rd_en;
    assign frame_err_tick  = (in_check & frame_bad) | tmo_expire;
    assign parity_err_tick = in_check & ~frame_bad & parity_bad;

    // ---------------- receive FIFO ----------------
    ps2_rx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (frame_q[8:1]),
        .rd_en   (rd_en),
        .rd_data (dout),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_ps2_rx_buf.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_buf
// Drives PS/2 frames (directed, then randomized with glitches, bad frames,
// truncated frames and random reads) and checks every cycle against a
// frame-level reference model built from bit lists and a byte queue.
// ---------------------------------------------------------------------------
module tb_ps2_rx_buf;

    localparam int FL    = 4;
    localparam int AW    = 2;
    localparam int TMO   = 150;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ps2d;
    logic          ps2c;
    logic          rx_en;
    logic          rd_en;
    logic          rd_dir;
    logic          rd_rnd;
    logic          rd_rand_en;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          rx_done_tick;
    logic          frame_err_tick;
    logic          parity_err_tick;
    logic          overflow_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_done = -1;
    int last_ferr = -1;
    int last_perr = -1;
    int last_ovf  = -1;

    assign rd_en = rd_dir | (rd_rand_en & rd_rnd);

    ps2_rx_buf #(
        .FILTER_LEN  (FL),
        .FIFO_AW     (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2d            (ps2d),
        .ps2c            (ps2c),
        .rx_en           (rx_en),
        .rd_en           (rd_en),
        .dout            (dout),
        .empty           (empty),
        .full            (full),
        .count           (count),
        .rx_done_tick    (rx_done_tick),
        .frame_err_tick  (frame_err_tick),
        .parity_err_tick (parity_err_tick),
        .overflow_tick   (overflow_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Filtered clock: high after FL consecutive high samples, low after FL
    // consecutive low samples. Frames are bit lists; FIFO is a byte queue.
    bit         m_filt;
    int         hi_run, lo_run, gap;
    bit         in_frame, pend;
    logic       bits[$];
    logic [7:0] fifo[$];

    always @(negedge clk) begin
        bit         nf, fe, pop, push, e_done, e_ferr, e_perr, e_ovf;
        logic [7:0] d;
        int         ones;
        if (reset) begin
            m_filt = 0; hi_run = 0; lo_run = 0; gap = 0;
            in_frame = 0; pend = 0; bits.delete(); fifo.delete();
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_count", count, 0);
            chk("rst_dout", dout, 0);
            chk("rst_ticks", {rx_done_tick, frame_err_tick, parity_err_tick, overflow_tick}, 0);
        end else begin
            if (ps2c) begin hi_run++; lo_run = 0; end
            else begin lo_run++; hi_run = 0; end
            nf = (hi_run >= FL) ? 1'b1 : (lo_run >= FL) ? 1'b0 : m_filt;
            fe = m_filt && !nf;
            m_filt = nf;
            e_done = 0; e_ferr = 0; e_perr = 0; e_ovf = 0; push = 0; d = 8'h00;
            pop = rd_en && (fifo.size() > 0);

            chk("empty", empty, fifo.size() == 0);
            chk("full", full, fifo.size() == DEPTH);
            chk("count", count, fifo.size());
            if (fifo.size() > 0) chk("dout", dout, fifo[0]);

            if (pend) begin
                pend = 0;
                ones = 0;
                for (int i = 0; i < 8; i++) begin
                    d[i] = bits[1+i];
                    ones += int'(bits[1+i]);
                end
                ones += int'(bits[9]);
                if (bits[0] != 1'b0 || bits[10] != 1'b1) e_ferr = 1;
`ifdef PS2_RX_PARITY_CHECK_EN
                else if (ones % 2 == 0) e_perr = 1;
`endif
                else if (fifo.size() == DEPTH && !rd_en) e_ovf = 1;
                else begin e_done = 1; push = 1; end
            end else if (!in_frame) begin
                if (fe && rx_en) begin
                    bits.delete();
                    bits.push_back(ps2d);
                    in_frame = 1;
                    gap = 0;
                end
            end else if (fe) begin
                bits.push_back(ps2d);
                gap = 0;
                if (bits.size() == 11) begin
                    in_frame = 0;
                    pend = 1;
                end
            end else begin
                gap++;
                if (gap == TMO) begin
                    e_ferr = 1;
                    in_frame = 0;
                end
            end

            chk("rx_done_tick", rx_done_tick, e_done);
            chk("frame_err_tick", frame_err_tick, e_ferr);
            chk("parity_err_tick", parity_err_tick, e_perr);
            chk("overflow_tick", overflow_tick, e_ovf);

            if (rx_done_tick)    last_done = cyc;
            if (frame_err_tick)  last_ferr = cyc;
            if (parity_err_tick) last_perr = cyc;
            if (overflow_tick)   last_ovf  = cyc;

            if (pop)  void'(fifo.pop_front());
            if (push) fifo.push_back(d);
        end
    end

    // ---------------- stimulus helpers ----------------
    initial begin
        rd_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_rnd = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit par_flip,
                                       input bit stop, input bit start);
        return {stop, (~^d) ^ par_flip, d, start};
    endfunction

    // High phase (with optional low glitch), then ps2c driven low; returns
    // the cycle in which the low level first appears.
    task automatic send_bit(input logic b, input int glitch, output int low_cyc);
        ps2d = b;
        ps2c = 1'b1;
        tick_n($urandom_range(FL, FL + 3));
        if (glitch > 0) begin
            ps2c = 1'b0;
            tick_n(glitch);
            ps2c = 1'b1;
            tick_n($urandom_range(FL, FL + 3));
        end
        ps2c = 1'b0;
        low_cyc = cyc;
    endtask

    task automatic send_frame(input logic [10:0] fr, input int nbits, input bit glitchy,
                              input bit drop_en, input bit rd_at_check, output int last_low);
        int lc;
        last_low = -1;
        for (int i = 0; i < nbits; i++) begin
            send_bit(fr[i], glitchy ? int'($urandom_range(1, FL - 1)) : 0, lc);
            if (i == nbits - 1 && rd_at_check) begin
                tick_n(FL);
                rd_dir = 1'b1;
                tick_n(1);
                rd_dir = 1'b0;
                tick_n(2);
            end else begin
                tick_n($urandom_range(FL, FL + 3));
            end
            if (drop_en && i == 2) rx_en = 1'b0;
            last_low = lc;
        end
        ps2c = 1'b1;
        tick_n(FL + 3);
    endtask

    task automatic read_chk(input string name, input logic [7:0] exp);
        chk(name, dout, exp);
        rd_dir = 1'b1;
        tick_n(1);
        rd_dir = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s, s4, l5, nb, r;
        logic [7:0] rb;
        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b0;
        rd_dir = 1'b0; rd_rand_en = 1'b0;
        tick_n(3);
        reset = 1'b0;
        tick_n(FL + 2);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_count", count, 0);
        rx_en = 1'b1;

        // Valid 0x1C: done tick one cycle after the stop-bit edge.
        send_frame(mk(8'h1C, 0, 1, 0), 11, 0, 0, 0, s);
        chk("t1_done_cycle", last_done, s + FL);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        read_chk("t1_dout", 8'h1C);
        chk("t1_empty_after_pop", empty, 1);

        // Bad parity on 0x1C.
        send_frame(mk(8'h1C, 1, 1, 0), 11, 0, 0, 0, s);
`ifdef PS2_RX_PARITY_CHECK_EN
        chk("t2_perr_cycle", last_perr, s + FL);
        chk("t2_count", count, 0);
`else
        chk("t2_done_cycle", last_done, s + FL);
        read_chk("t2_dout", 8'h1C);
`endif

        // Stop bit 0, then valid 0xF0.
        send_frame(mk(8'h5A, 0, 0, 0), 11, 0, 0, 0, s);
        chk("t3_ferr_cycle", last_ferr, s + FL);
        chk("t3_count", count, 0);
        send_frame(mk(8'hF0, 0, 1, 0), 11, 0, 0, 0, s);
        read_chk("t3_dout", 8'hF0);

        // Timeout after 5 edges, then recovery.
        send_frame(mk(8'h33, 0, 1, 0), 5, 0, 0, 0, l5);
        tick_n(TMO + FL + 10);
        chk("t4_tmo_cycle", last_ferr, l5 + FL - 1 + TMO);
        send_frame(mk(8'h1C, 0, 1, 0), 11, 0, 0, 0, s);
        read_chk("t4_dout", 8'h1C);

        // Fill and overflow.
        s4 = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(mk(8'(i), 0, 1, 0), 11, 0, 0, 0, s);
            if (i == 4) s4 = s;
        end
        chk("t5_count", count, 4);
        chk("t5_full", full, 1);
        chk("t5_ovf_cycle", last_ovf, s + FL);
        chk("t5_last_done", last_done, s4 + FL);
        for (int i = 1; i <= 4; i++) read_chk("t5_read", 8'(i));
        chk("t5_empty", empty, 1);

        // Full FIFO popped in the CHECK cycle still stores the new frame.
        for (int i = 1; i <= 4; i++) send_frame(mk(8'(i), 0, 1, 0), 11, 0, 0, 0, s);
        send_frame(mk(8'h05, 0, 1, 0), 11, 0, 0, 1, s);
        chk("t6_done_cycle", last_done, s + FL);
        chk("t6_count", count, 4);
        for (int i = 2; i <= 5; i++) read_chk("t6_read", 8'(i));

        // Short low glitches in IDLE and during a frame.
        ps2c = 1'b0; tick_n(FL - 1); ps2c = 1'b1; tick_n(FL + 2);
        chk("t7_idle_glitch_count", count, 0);
        send_frame(mk(8'hA5, 0, 1, 0), 11, 1, 0, 0, s);
        chk("t7_count", count, 1);
        read_chk("t7_dout", 8'hA5);

        // Reset mid-frame discards the partial frame.
        send_frame(mk(8'h77, 0, 1, 0), 4, 0, 0, 0, s);
        reset = 1'b1; tick_n(2); reset = 1'b0; tick_n(FL + 2);
        send_frame(mk(8'h3C, 0, 1, 0), 11, 0, 0, 0, s);
        read_chk("t8_dout", 8'h3C);

        // Randomized traffic; the model checks every cycle.
        rd_rand_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 11));
            rx_en = ($urandom_range(0, 7) != 0);
            nb = (r == 3) ? int'($urandom_range(1, 10)) : 11;
            send_frame(mk(rb, r == 0, r != 1, r == 2), nb, $urandom_range(0, 3) == 0,
                       r == 4, 0, s);
            if (r == 3) tick_n(TMO + 5);
            rx_en = 1'b1;
        end
        rd_rand_en = 1'b0;
        repeat (DEPTH + 1) begin
            rd_dir = 1'b1; tick_n(1);
        end
        rd_dir = 1'b0;
        tick_n(2);
        chk("final_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_buf.md
# ps2_rx_buf

Parametrised PS/2 device-to-host receiver with a glitch filter, full frame validation (start, stop, odd parity), inter-edge timeout recovery and an on-chip receive FIFO. It sits between the PS/2 pins (already synchronised) and the keyboard scan-code decoder. It replaces single-byte handoff with a buffered first-word-fall-through read interface and per-error status ticks.

## Interface
- FILTER_LEN, 8, ps2c glitch-filter length in clk cycles (≥2)
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW
- TIMEOUT_CYC, 20000, max clk cycles between falling edges inside a frame
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ps2d  in  1  PS/2 data, synchronised
- ps2c  in  1  PS/2 clock, synchronised
- rx_en  in  1  permits a new frame to start
- rd_en  in  1  pop FIFO head; ignored when empty
- dout  out  8  FIFO head byte (valid when !empty)
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  FIFO_AW+1  entries held
- rx_done_tick  out  1  one-cycle pulse: valid frame written to FIFO
- frame_err_tick  out  1  pulse: bad start/stop bit or timeout
- parity_err_tick  out  1  pulse: parity mismatch
- overflow_tick  out  1  pulse: valid frame dropped, FIFO full

## Operation
- Filter: FILTER_LEN-bit shift register of ps2c; filtered clock goes 1 when all ones, 0 when all zeros, else holds. fall_edge = filtered_reg & ~filtered_next (combinational, same cycle the filter resolves low).
- Frame: 11 bits LSB-first: start(0), d0..d7, odd parity, stop(1); each bit sampled from ps2d on fall_edge, shifted into an 11-bit register from the MSB side.
- FSM states IDLE, DPS, CHECK:
  - IDLE: fall_edge & rx_en → shift bit, n=9, clear timeout counter, → DPS. fall_edge without rx_en ignored.
  - DPS: fall_edge → shift, clear timeout counter; n==0 → CHECK else n−1. No edge → counter +1; counter reaches TIMEOUT_CYC → frame_err_tick, → IDLE.
  - CHECK (1 cycle): start≠0 or stop≠1 → frame_err_tick; else parity bad → parity_err_tick; else FIFO write (or overflow_tick if full and no pop this cycle) plus rx_done_tick. Always → IDLE.
- rx_en deassertion mid-frame does not abort the frame.
- FIFO: write on CHECK-accept; full & rd_en same cycle → pop and write both succeed, count unchanged. empty & rd_en → no effect. Pointers wrap modulo depth.

## Timing
- Reset: state IDLE, shift reg/counters/pointers 0, dout 0, empty 1, full 0, count 0, all ticks 0. Reset mid-frame discards the partial frame.
- Latency: stop-bit fall_edge in cycle N → CHECK in N+1 (ticks asserted) → empty falls, dout valid in N+2.
- dout reflects head combinationally from registered storage; pop updates on next edge.
- At most one tick is asserted per frame (priority frame > parity > overflow/done).

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity checked as above.
- Undefined: parity bit ignored, bad-parity frames accepted, parity_err_tick tied 0.

## Structure
- Package ps2_pkg: FSM state encoding, FRAME_BITS=11, parameter defaults.
- Sub-module ps2_rx_fifo (synchronous FWFT FIFO, parameter FIFO_AW, width 8); filter and FSM stay in top.

## Test plan
- Frame 0x1C, parity 0, stop 1 → rx_done_tick at N+1, dout=0x1C, empty=0 at N+2, count=1; rd_en → empty=1.
- Frame 0x1C with parity 1 → parity_err_tick, FIFO unchanged; with macro off → dout=0x1C accepted.
- Stop bit 0 (0x5A) → frame_err_tick, no write; next valid 0xF0 received correctly.
- ps2c stops after 5 edges → frame_err_tick exactly TIMEOUT_CYC cycles after last edge, state IDLE; subsequent 0x1C accepted.
- FIFO_AW=2, frames 0x01..0x05 without reads → count=4, full=1, overflow_tick on 5th; reads return 0x01..0x04; repeat with rd_en pulsed in 5th frame's CHECK cycle → 0x05 stored.
- ps2c low glitch of FILTER_LEN−1 cycles in IDLE and DPS → no fall_edge, no bit shifted.
